// File: rtl/gf_horner_eval.sv
// gf_horner_eval
// Sequential GF(2^8) polynomial evaluator (field polynomial 0x11D). Coefficient
// bytes arrive highest degree first and are folded in by Horner's rule:
// acc = acc * x ^ byte. The multiply is bit-serial, MSB first, over 8 cycles,
// so each byte takes 9 cycles (1 LOAD + 8 MULT).
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset
//   start_i       begin an evaluation (honoured only when idle)
//   point_i       evaluation point x, sampled on accepted start
//   len_i         number of coefficient bytes, sampled on accepted start
//   data_valid_i  coefficient byte valid
//   data_i        coefficient byte
//   data_ready_o  block can accept a byte (LOAD state)
//   busy_o        evaluation in progress
//   done_o        one-cycle pulse, result_o holds the new result
//   result_o      last completed evaluation
module gf_horner_eval #(
  parameter int IO_WIDTH  = 8,
  parameter int PP_CHAR   = 29,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [IO_WIDTH-1:0]  point_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 data_valid_i,
  input  logic [IO_WIDTH-1:0]  data_i,
  output logic                 data_ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IO_WIDTH-1:0]  result_o
);

  localparam int BW = $clog2(IO_WIDTH);
  localparam logic [IO_WIDTH-1:0] PP_C     = IO_WIDTH'(PP_CHAR);
  localparam logic [BW-1:0]       LAST_BIT = BW'(IO_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MULT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Multiply by x modulo the field polynomial (the top bit folds back in).
  function automatic logic [IO_WIDTH-1:0] xtime(input logic [IO_WIDTH-1:0] p);
    xtime = {p[IO_WIDTH-2:0], 1'b0} ^ (p[IO_WIDTH-1] ? PP_C : {IO_WIDTH{1'b0}});
  endfunction

  state_t               state_r, state_n;
  logic [IO_WIDTH-1:0]  point_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [IO_WIDTH-1:0]  acc_r;
  logic [IO_WIDTH-1:0]  byte_r;
  logic [IO_WIDTH-1:0]  prod_r;
  logic [IO_WIDTH-1:0]  pt_sh_r;   // copy of point shifted left so the MSB is the current bit
  logic [BW-1:0]        bit_r;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic                 ready_r;
  logic                 busy_r;
  logic                 done_r;
  logic [IO_WIDTH-1:0]  result_r;

  logic [IO_WIDTH-1:0]  prod_s;
  logic [LEN_WIDTH-1:0] cnt_inc_s;
  logic                 last_bit_s;
  logic                 accept_s;

  // Next-state decode and the combinational shift-and-add step.
  always_comb begin
    state_n    = state_r;
    prod_s     = xtime(prod_r) ^ (pt_sh_r[IO_WIDTH-1] ? acc_r : {IO_WIDTH{1'b0}});
    cnt_inc_s  = cnt_r + LEN_WIDTH'(1);
    last_bit_s = (bit_r == LAST_BIT);
    accept_s   = data_valid_i && ready_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_n = (len_i == {LEN_WIDTH{1'b0}}) ? ST_DONE : ST_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          state_n = ST_MULT;
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_MULT: begin
        if (last_bit_s) begin
          state_n = (cnt_inc_s == len_r) ? ST_DONE : ST_LOAD;
        end else begin
          state_n = ST_MULT;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      point_r  <= {IO_WIDTH{1'b0}};
      len_r    <= {LEN_WIDTH{1'b0}};
      acc_r    <= {IO_WIDTH{1'b0}};
      byte_r   <= {IO_WIDTH{1'b0}};
      prod_r   <= {IO_WIDTH{1'b0}};
      pt_sh_r  <= {IO_WIDTH{1'b0}};
      bit_r    <= {BW{1'b0}};
      cnt_r    <= {LEN_WIDTH{1'b0}};
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {IO_WIDTH{1'b0}};
    end else begin
      state_r <= state_n;
      ready_r <= (state_n == ST_LOAD);
      busy_r  <= (state_n != ST_IDLE);
      done_r  <= (state_n == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            point_r <= point_i;
            len_r   <= len_i;
            acc_r   <= {IO_WIDTH{1'b0}};
            cnt_r   <= {LEN_WIDTH{1'b0}};
            // len=0 goes straight to DONE with an empty (zero) result
            if (len_i == {LEN_WIDTH{1'b0}}) begin
              result_r <= {IO_WIDTH{1'b0}};
            end
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            byte_r  <= data_i;
            bit_r   <= {BW{1'b0}};
            prod_r  <= {IO_WIDTH{1'b0}};
            pt_sh_r <= point_r;
          end
        end
        ST_MULT: begin
          prod_r  <= prod_s;
          pt_sh_r <= {pt_sh_r[IO_WIDTH-2:0], 1'b0};
          bit_r   <= bit_r + BW'(1);
          if (last_bit_s) begin
            acc_r <= prod_s ^ byte_r;
            cnt_r <= cnt_inc_s;
            // Publish the result as DONE is entered so it is valid alongside done_o
            if (cnt_inc_s == len_r) begin
              result_r <= prod_s ^ byte_r;
            end
          end
        end
        ST_DONE: begin
          result_r <= acc_r;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_ready_o = ready_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign result_o     = result_r;

endmodule

// File: doc/gf_horner_eval.md
# gf_horner_eval

Sequential GF(2^8) polynomial evaluator: accepts a stream of coefficient bytes and evaluates the polynomial at a programmable point by Horner's rule (acc = acc·x ⊕ byte). It sits directly downstream of the byte multiplier stage and is the consumer that turns codeword bytes into Reed-Solomon syndromes. It uses the same field (x^8+x^4+x^3+x^2+1, 0x11D). It contains its own bit-serial multiplier, so one byte is processed per 9 cycles with no combinational multiply.

## Interface
- IO_WIDTH, 8, symbol width; only 8 is supported.
- PP_CHAR, 29, low byte of the primitive polynomial (0x1D).
- LEN_WIDTH, 8, width of the byte-count input.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin an evaluation; honoured only in IDLE.
- point_i  in  IO_WIDTH  evaluation point x; sampled on accepted start.
- len_i  in  LEN_WIDTH  number of coefficient bytes; sampled on accepted start.
- data_valid_i  in  1  coefficient byte valid.
- data_i  in  IO_WIDTH  coefficient byte; highest degree first.
- data_ready_o  out  1  block can accept a byte.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse: result_o updated.
- result_o  out  IO_WIDTH  last completed evaluation.

## Operation
- States: IDLE, LOAD, MULT, DONE.
- IDLE: data_ready_o=0. start_i=1 latches point and len, clears acc and the byte counter, then goes to LOAD. If len_i=0, it goes to DONE instead.
- LOAD: data_ready_o=1. On data_valid_i&data_ready_o, latch data_i, clear the bit counter and go to MULT. Without valid, stay in LOAD indefinitely.
- MULT: 8 cycles, MSB-first shift-and-add of acc·point.
  - Product p starts at 0.
  - Each cycle for bit i=7..0: p = xtime(p) ⊕ (point[i] ? acc : 0).
  - xtime(p) = {p[6:0],0} ⊕ (p[7] ? PP_CHAR : 0).
  - All arithmetic is 8-bit XOR; no carries.
  - On the 8th cycle, acc <= p ⊕ latched byte and the byte counter increments. If the count equals len, go to DONE; otherwise go to LOAD.
- DONE: result_o <= acc (len=0 gives 0x00), done_o=1 for this cycle, then go to IDLE.
- start_i outside IDLE is ignored; point and len stay stable for the whole evaluation.
- result_o holds its value until the next DONE. It is not cleared by start.
- rst_i at any cycle, including mid-MULT:
  - Next state is IDLE.
  - acc, result_o and all counters are cleared to 0.
  - Any in-flight byte is discarded.
- Reset values: data_ready_o=0, busy_o=0, done_o=0, result_o=0x00.

## Timing
- Start accepted in cycle 0 → LOAD from cycle 1.
- A byte accepted in cycle t → MULT in t+1..t+8, acc updated at the end of t+8.
- After that update, LOAD (ready high) or DONE occurs in t+9.
- With valid held high, an N-byte evaluation raises done_o in cycle 9N+1 and returns to IDLE in 9N+2.
- With len=0: done_o in cycle 1.
- A new start is accepted in the first IDLE cycle after DONE.
- data_ready_o is low in every MULT cycle; data_i is don't-care there.

## Test plan
- point=0x02, len=2, bytes 0x01,0x00, valid held high → done_o in cycle 19, result_o=0x02; data_ready_o high only in cycles 1 and 10.
- point=0x80, len=2, bytes 0x80,0x00 → result_o=0x13 (x^14 mod 0x11D); point=0x02 with the same bytes → 0x1D (reduction path).
- point=0x01, len=3, bytes 0x12,0x34,0x56 → 0x70. point=0x00 with the same bytes → 0x56. point=0x02, bytes 0x01,0x02 → 0x00 (root).
- Backpressure: point=0x01, bytes 0x12,0x34,0x56 with valid low for 5 cycles before each byte → result 0x70, done_o delayed by exactly 15 cycles.
- len=0 → done_o in cycle 1, result 0x00. start_i pulsed during MULT → ignored; the running result is unchanged.
- rst_i asserted in the 4th MULT cycle → next cycle IDLE, busy_o=0, result_o=0x00, no done_o. A subsequent clean run returns the correct result.
